// File: rtl/bitpack_ssm.sv
// Substream bit packer: concatenates 1-128 bit MSB-aligned groups into an MSB-first bitstream
// and emits it as 128-bit words; a flush zero-pads and emits the final partial word.
module bitpack_ssm #(
    parameter int unsigned ssm_idx = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             se_valid,
    output logic             se_ready,
    input  logic [127:0]     se_data,
    input  logic [7:0]       se_len,
    input  logic             flush,
    output logic             flush_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [7:0]       fill,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [0:0] {StRun, StFlush} state_t;

    // ssm_idx is a debug label and must fit a byte
    if (CNT_W == 0 || ssm_idx > 255) begin : g_param_chk
        $error("bitpack_ssm: CNT_W must be nonzero and ssm_idx must be below 256");
    end

    state_t       state;
    logic [254:0] acc;

    logic         slot_free;
    logic         emit;
    logic         accept;
    logic [7:0]   len;
    logic [127:0] grp;
    logic [7:0]   fill_base;
    logic [254:0] acc_base;
    logic [7:0]   fill_next;
    logic [254:0] acc_next;

    always_comb begin
        len       = (se_len > 8'd128) ? 8'd128 : se_len;
        grp       = se_data & ~({128{1'b1}} >> len);
        slot_free = !out_valid | out_ready;
        emit      = slot_free & ((fill >= 8'd128) | ((state == StFlush) & (fill != 8'd0)));
        // Gated by rstn so the packer never advertises readiness while held in reset
        se_ready  = rstn & (state == StRun) & ((fill < 8'd128) | emit);
        accept    = se_valid & se_ready;

        if (emit) begin
            fill_base = (fill >= 8'd128) ? (fill - 8'd128) : 8'd0;
            acc_base  = {acc[126:0], 128'b0};
        end else begin
            fill_base = fill;
            acc_base  = acc;
        end

        fill_next = fill_base;
        acc_next  = acc_base;
        if (accept) begin
            // New group lands directly after the residual bits; bits below stay zero
            acc_next  = acc_base | ({grp, 127'b0} >> fill_base);
            fill_next = fill_base + len;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StRun;
            acc        <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            word_cnt   <= '0;
            flush_done <= 1'b0;
        end else begin
            acc        <= acc_next;
            fill       <= fill_next;
            flush_done <= 1'b0;

            if (emit) begin
                out_data  <= acc[254:127];
                out_valid <= 1'b1;
                word_cnt  <= word_cnt + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                StRun: begin
                    if (flush) state <= StFlush;
                end
                StFlush: begin
                    // Done once nothing is buffered and the last word is being taken (or gone)
                    if (fill == 8'd0 && slot_free) begin
                        state      <= StRun;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

endmodule

// File: doc/bitpack_ssm.md
# bitpack_ssm

Encoder-side substream packer: the transmit counterpart of the decoder's per-substream bit parser. Accepts one variable-length syntax-element group per handshake (1–128 bits, MSB-aligned) and concatenates the groups MSB-first into a continuous bitstream. Emits the bitstream as 128-bit words to the substream multiplexer FIFO. Supports an end-of-slice flush that zero-pads the final partial word.

## Interface
- `ssm_idx`, 0, substream index; debug labelling only, no functional effect.
- `CNT_W`, 16, width of the emitted-word counter.
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `se_valid`  in  1  syntax-element group valid.
- `se_ready`  out  1  packer can accept a group this cycle.
- `se_data`  in  128  group bits, first bit at `se_data[127]`; bits below the length are don't-care.
- `se_len`  in  8  group length in bits; 0 = no-op; values >128 clamp to 128.
- `flush`  in  1  end-of-slice request; sampled only in RUN.
- `flush_done`  out  1  one-cycle pulse when a flush has completed.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  128  packed word, first bit at `out_data[127]`.
- `fill`  out  8  bits held in the accumulator (0–255).
- `word_cnt`  out  CNT_W  words emitted since reset; wraps.

## Operation
- The accumulator `acc[254:0]` holds `fill` valid bits at `acc[254 -: fill]`. All bits below the valid bits are always 0.
- Masking: the incoming group is first masked to its top `se_len` bits. It is then placed at `acc[254-fill' -: len]`.
- `fill'` is `fill`, or `fill-128` when an emit happens in the same cycle.
- Slot free: `slot_free = !out_valid | out_ready`.
- Emit condition: `emit = (fill >= 128) & slot_free`, or, in FLUSH only, `(fill > 0) & slot_free`.
- On emit:
  - `out_data <= acc[254:127]`; `out_valid <= 1`; `word_cnt` increments.
  - `acc` shifts left by 128. `fill` drops by 128, floored at 0 in FLUSH.
- Padding: a flush word with `fill < 128` carries its valid bits followed by zeros.
- `se_ready = (state==RUN) & ((fill < 128) | emit)`. This is combinational and depends on `out_ready`. Capacity is guaranteed: after an emit, `fill ≤ 127`, plus 128 gives at most 255.
- Accept and emit may occur in the same cycle. The new group is appended after the residual bits.
- `out_valid` clears when `out_ready` is high and no new emit occurs. `out_data` holds its value while `out_valid & !out_ready`.
- State machine:
  - RUN: `flush` high moves to FLUSH. A group handshaked in the same cycle is accepted first.
  - FLUSH: `se_ready = 0`. Emits continue until `fill == 0` and `out_valid == 0`; then `flush_done` pulses and the state returns to RUN with `fill = 0`.
- Flush with nothing buffered: a flush with `fill == 0` and `!out_valid` completes on the next cycle with no word emitted.
- `se_len == 0` with `se_valid` is accepted (handshake completes) and does not change `fill`.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `se_ready = 0` during reset (state RUN, `fill = 0`, so it is 1 after reset deasserts), `flush_done = 0`, `fill = 0`, `word_cnt = 0`, `acc = 0`.
- Accept at edge E updates `fill` and `acc` at E. If the resulting `fill ≥ 128` and the slot is free, the word is registered at E+1, so `out_valid` is high in the cycle after E+1.
- Sustained throughput: one group per cycle while downstream takes one word per cycle.
- `flush_done` is asserted the cycle after the last word's `out_valid & out_ready` handshake.
- Reset mid-operation: all state clears immediately. Buffered bits and any pending word are discarded.

## Test plan
- Reset, then four groups of len 32 (`0xAAAAAAAA`, `0xBBBBBBBB`, `0xCCCCCCCC`, `0xDDDDDDDD`), `out_ready = 1`:
  - exactly one word `0xAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD`;
  - `fill` returns to 0; `word_cnt = 1`.
- Groups len 100, then len 100, each all-ones:
  - word 1 is all-ones;
  - `fill = 72` afterwards;
  - `flush` emits `{72 ones, 56 zeros}`, then `flush_done` pulses; `fill = 0`.
- `out_ready = 0` with one word pending and `fill = 200`:
  - `se_ready = 0`; `out_data` holds its value;
  - raise `out_ready`: the emit and an accept of len 80 occur in the same cycle, giving `fill = 152`.
- Back-to-back len-128 groups for 16 cycles with `out_ready = 1`:
  - `se_ready` stays 1 throughout;
  - 16 words out, bit-exact; `word_cnt = 16`.
- Flush with `fill = 0` and no pending word: `flush_done` the next cycle, no `out_valid`.
- Flush arriving in the same cycle as a len-8 `0x5A` handshake: the final word is `0x5A` followed by 120 zeros.
- Assert `rstn` low while in FLUSH with `fill = 40`:
  - all outputs return to reset values;
  - after release, no stale word appears.
